// File: rtl/legv8_pkg.sv
// Shared constants, state encoding and XZR helper for the LEGv8 register file.
// Pure definitions: no logic, no latency, no flow control.
package legv8_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int NREGS_DEF  = 32;

  typedef enum logic {INIT, RUN} rf_state_e;

  function automatic int xzr_idx(input int nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/legv8_regfile_clr.sv
// Clear sequencer: zeroes entries 0..NREGS-2 one per cycle after reset, then idles in RUN.
// Latency NREGS-1 cycles from reset release; no backpressure, it always advances.
module legv8_regfile_clr
  import legv8_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 2);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // XZR is never stored, so the sweep stops one short of the top index.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    clr_we      = 1'b0;
    clr_addr    = r_cnt;
    init_busy   = 1'b0;
    if (r_state == INIT) begin
      clr_we    = 1'b1;
      init_busy = 1'b1;
      w_cnt_nxt = r_cnt + AW'(1);
      if (r_cnt == LAST_IDX) begin
        w_state_nxt = RUN;
      end
    end
  end

endmodule

// File: rtl/legv8_regfile_mp.sv
// Multi-read-port LEGv8 register file: registered reads with same-cycle write forwarding, XZR reads 0.
// Read latency 1 cycle; no stalls in RUN, user writes during INIT are dropped and flagged on wr_drop.
module legv8_regfile_mp
  import legv8_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [AW-1:0]         WR,
  input  logic [DATA_W-1:0]     WD,
  input  logic [NRD-1:0]        RE,
  input  logic [NRD*AW-1:0]     RR,
  output logic [NRD*DATA_W-1:0] RD,
  output logic                  init_busy,
  output logic                  wr_drop
);

  localparam logic [AW-1:0] XZR = AW'(xzr_idx(NREGS));

  logic              w_clr_we;
  logic [AW-1:0]     w_clr_addr;
  logic              w_wr_real;
  logic              w_user_we;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdat;
  logic              r_wr_drop;
  logic [DATA_W-1:0] r_mem [NREGS];

  legv8_regfile_clr #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr),
    .init_busy (init_busy)
  );

  assign w_wr_real = RegWrite && (WR != XZR);
  assign w_user_we = w_wr_real && !init_busy;
  assign w_we      = w_clr_we || w_user_we;
  assign w_waddr   = init_busy ? w_clr_addr : WR;
  assign w_wdat    = init_busy ? '0 : WD;

  // Storage has no reset; the sequencer owns its initial contents.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_real && init_busy;
    end
  end

  assign wr_drop = r_wr_drop;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]     w_rr;
    logic [DATA_W-1:0] r_rd;

    assign w_rr = RR[p*AW +: AW];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd <= '0;
      end else if (RE[p]) begin
        if (init_busy || (w_rr == XZR)) begin
          r_rd <= '0;
        end else if (w_user_we && (w_rr == WR)) begin
          r_rd <= WD;
        end else begin
          r_rd <= r_mem[w_rr];
        end
      end
    end

    assign RD[p*DATA_W +: DATA_W] = r_rd;
  end

endmodule

// File: doc/legv8_regfile_mp.md
# legv8_regfile_mp

Parametrised multi-read-port register file for the LEGv8 datapath. It replaces the fixed two-read/one-write 64-bit file with configurable width, depth and read-port count. Reads are registered with same-cycle write forwarding, and the highest-index register is hard-wired zero (XZR). After reset, an internal sequencer zeroes every storage entry, one per cycle, before the file accepts writes.

## Interface
Parameters:
- DATA_W, 64, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 4)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), register-index width (derived, not overridden)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- RegWrite  in  1  write enable
- WR  in  AW  write register index
- WD  in  DATA_W  write data
- RE  in  NRD  per-port read enable
- RR  in  NRD*AW  read indices, port p at bits [p*AW +: AW]
- RD  out  NRD*DATA_W  read data, port p at bits [p*DATA_W +: DATA_W]
- init_busy  out  1  high while the clear sequencer is running
- wr_drop  out  1  one-cycle pulse when a RegWrite is discarded during init

## Operation
- XZR = NREGS-1. A read of XZR always returns 0. A write to XZR is silently discarded. It does not pulse wr_drop.
- States: INIT, RUN.
- Reset puts the block in INIT with clear counter = 0.
- In INIT, each cycle writes 0 to entry[counter] and increments the counter. After writing entry NREGS-2, the block goes to RUN on the next edge. INIT therefore lasts NREGS-1 cycles.
- In RUN, when RegWrite=1 and WR≠XZR, entry[WR] ← WD at the rising edge.
- In INIT, user writes are discarded. wr_drop=1 on the following cycle for each cycle with RegWrite=1 and WR≠XZR.
- Reads on each port p:
  - If RE[p]=1, RD_p ← value of entry[RR_p] at the next edge.
  - If RE[p]=0, RD_p holds its value.
- Forwarding: in RUN, if RE[p]=1, RegWrite=1, RR_p==WR and WR≠XZR in the same cycle, RD_p ← WD (new data, not stale).
- Reads during INIT are allowed. They return 0 for already-cleared entries and for entries not yet cleared. The sequencer forces zero on every read issued in INIT.
- All read ports are independent. Any number of ports may read the same index in one cycle.

## Timing
- Reset values: RD = 0, init_busy = 1, wr_drop = 0, state = INIT, counter = 0.
- Storage array is not reset directly; the sequencer clears it.
- Reset asserted mid-INIT or mid-RUN: outputs return to reset values immediately (asynchronously). After deassertion, INIT restarts from entry 0.
- init_busy falls on the edge that enters RUN. The first accepted write is the one presented in the cycle when init_busy is first low.
- Read latency is 1 cycle (RR sampled at edge N, RD valid after edge N). Write-to-read latency is 0 cycles via forwarding.
- Write-then-read of the same index in consecutive cycles returns the new value from the array.
- Throughput: one write and NRD reads per cycle, with no stalls in RUN.

## Structure
- Shared package legv8_pkg holds:
  - default DATA_W and NREGS constants
  - the XZR index function/constant (NREGS-1)
  - the state enum {INIT, RUN}
- Sub-module legv8_regfile_clr holds the clear sequencer:
  - contains the counter, state and init_busy logic
  - outputs clr_we and clr_addr
- The top level muxes the clear port and the user write port into one array write port and generates the NRD read ports with a generate loop.

## Test plan
- Reset then idle: init_busy=1 for exactly 31 cycles (NREGS=32), then 0. Reading every index 0..31 returns 0.
- After INIT, write X5=0xDEAD_BEEF_0000_0001, read X5 on both ports next cycle → both RD = 0xDEAD_BEEF_0000_0001 one cycle after RR presented.
- Same-cycle write X7=0x1234 and read RR0=7 with RE0=1 → RD0=0x1234 after that edge. Prior contents of X7 are never visible.
- Write X31=0xFFFF…FF in RUN, then read X31 → RD=0 and wr_drop stays 0. Write X3 during INIT → wr_drop pulses once, and a later read of X3 returns 0.
- Port hold and independence: write X1=0xA and X2=0xB. Then set RE=2'b01, RR0=2, RR1=1 → RD0=0xB and RD1 retains its previous value.
- Reset mid-RUN after writing X4=0x55: rst pulse → RD=0 immediately and init_busy=1. After INIT, reading X4 returns 0. Repeat with NRD=4, DATA_W=32.
